// File: rtl/int_div_regfile_multi_pkg.sv
// Shared types and helpers for the iterative divider with register-file writeback.
package int_div_regfile_multi_pkg;

    // Widest operand the magnitude helper handles.
    localparam int unsigned DIV_MAX_W = 64;

    typedef enum logic [2:0] {
        DIV_IDLE       = 3'd0,
        DIV_CALC       = 3'd1,
        DIV_WRITE_QUOT = 3'd2,
        DIV_WRITE_MOD  = 3'd3
    } e_div_state;

    // Magnitude of a width-bit value held zero-extended in a DIV_MAX_W container.
    // The most negative value maps onto itself, which reads correctly as unsigned.
    function automatic logic [DIV_MAX_W-1:0] div_abs(input logic [DIV_MAX_W-1:0] value,
                                                     input int unsigned width,
                                                     input logic is_signed);
        logic [DIV_MAX_W-1:0] mask;
        logic                 sign_bit;
        mask     = (width >= DIV_MAX_W) ? '1 : ((DIV_MAX_W'(1) << width) - DIV_MAX_W'(1));
        sign_bit = |(value & (DIV_MAX_W'(1) << (width - 1)));
        if (is_signed && sign_bit)
            div_abs = (-value) & mask;
        else
            div_abs = value & mask;
    endfunction

endpackage

// File: rtl/int_div_regfile_multi_if.sv
// Request side and register-file write port of the divider.
interface int_div_regfile_multi_if #(
    parameter int data_width    = 32,
    parameter int reg_sel_width = 5
);
    logic                     req;
    logic                     is_signed;
    logic [reg_sel_width-1:0] r_quot_sel;
    logic [reg_sel_width-1:0] r_mod_sel;
    logic [data_width-1:0]    a;
    logic [data_width-1:0]    b;
    logic                     busy;
    logic [reg_sel_width-1:0] rf_wr_sel;
    logic [data_width-1:0]    rf_wr_data;
    logic                     rf_wr_req;
    logic                     rf_wr_ack;

    // Issuer of requests and owner of the register file.
    modport master (
        output req, is_signed, r_quot_sel, r_mod_sel, a, b, rf_wr_ack,
        input  busy, rf_wr_sel, rf_wr_data, rf_wr_req
    );

    // The divider itself.
    modport slave (
        input  req, is_signed, r_quot_sel, r_mod_sel, a, b, rf_wr_ack,
        output busy, rf_wr_sel, rf_wr_data, rf_wr_req
    );
endinterface

// File: rtl/int_div_regfile_multi_step.sv
// Combinational restoring-division slice: bits_per_cycle iterations, MSB first.
module int_div_regfile_multi_step #(
    parameter int data_width     = 32,
    parameter int bits_per_cycle = 1
) (
    input  logic [data_width-1:0]     rem_in,
    input  logic [bits_per_cycle-1:0] dvd_bits,
    input  logic [data_width-1:0]     divisor,
    output logic [data_width-1:0]     rem_out,
    output logic [bits_per_cycle-1:0] quot_bits
);

    // Shift in one dividend bit per iteration; subtract the divisor when it fits.
    // The extra top bit holds the shifted-out MSB so the compare never overflows.
    always_comb begin
        logic [data_width:0] part;
        part      = {1'b0, rem_in};
        quot_bits = '0;
        for (int i = bits_per_cycle - 1; i >= 0; i--) begin
            part = {part[data_width-1:0], dvd_bits[i]};
            if (part >= {1'b0, divisor}) begin
                part         = part - {1'b0, divisor};
                quot_bits[i] = 1'b1;
            end
        end
        rem_out = part[data_width-1:0];
    end

endmodule

// File: rtl/int_div_regfile_multi.sv
// Iterative signed/unsigned divider that writes quotient and remainder back
// through a req/ack register-file port.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// IDLE           | waiting for req; busy low
// CALC           | restoring division, sign fixup on the last iteration
// WRITE_QUOT     | presenting quotient to the register file until acked
// WRITE_MOD      | presenting remainder to the register file until acked

`define INT_DIV_ASSERT_KNOWN(expr, msg) assert (!$isunknown(expr)) else $error(msg)

module int_div_regfile_multi
    import int_div_regfile_multi_pkg::*;
#(
    parameter int data_width     = 32,
    parameter int num_regs       = 32,
    parameter int bits_per_cycle = 1
) (
    input logic                  clk,
    input logic                  rst,
    int_div_regfile_multi_if.slave bus
);

    localparam int reg_sel_width = $clog2(num_regs);
    localparam int steps         = data_width / bits_per_cycle;
    localparam int cnt_width     = $clog2(steps) + 1;

    localparam logic [2:0] ST_IDLE       = DIV_IDLE;
    localparam logic [2:0] ST_CALC       = DIV_CALC;
    localparam logic [2:0] ST_WRITE_QUOT = DIV_WRITE_QUOT;
    localparam logic [2:0] ST_WRITE_MOD  = DIV_WRITE_MOD;

    if (!(bits_per_cycle == 1 || bits_per_cycle == 2 || bits_per_cycle == 4) ||
        (data_width % bits_per_cycle) != 0 || data_width > DIV_MAX_W) begin : g_bad_params
        $error("int_div_regfile_multi: bits_per_cycle must be 1, 2 or 4 and divide data_width");
    end

    logic [2:0]                state;
    logic [cnt_width-1:0]      cnt;
    logic                      neg_q;
    logic                      neg_r;
    logic [reg_sel_width-1:0]  quot_sel;
    logic [reg_sel_width-1:0]  mod_sel;
    logic [data_width-1:0]     quot;
    logic [data_width-1:0]     rem;
    logic [data_width-1:0]     divisor;
    logic                      wr_req;
    logic [reg_sel_width-1:0]  wr_sel;
    logic [data_width-1:0]     wr_data;

    logic [data_width-1:0]     abs_a;
    logic [data_width-1:0]     abs_b;
    logic                      is_div0;
    logic                      is_ovf;
    logic [data_width-1:0]     step_rem;
    logic [bits_per_cycle-1:0] step_quot;
    logic [data_width-1:0]     quot_shift;
    logic [data_width-1:0]     quot_fixed;
    logic [data_width-1:0]     rem_fixed;

    function automatic logic [2:0] first_write(input logic [reg_sel_width-1:0] qs,
                                               input logic [reg_sel_width-1:0] ms);
        if (qs != '0)
            return ST_WRITE_QUOT;
        if (ms != '0)
            return ST_WRITE_MOD;
        return ST_IDLE;
    endfunction

    assign abs_a   = data_width'(div_abs(DIV_MAX_W'(bus.a), data_width, bus.is_signed));
    assign abs_b   = data_width'(div_abs(DIV_MAX_W'(bus.b), data_width, bus.is_signed));
    assign is_div0 = (bus.b == '0);
    assign is_ovf  = bus.is_signed && (bus.a == {1'b1, {(data_width-1){1'b0}}}) && (bus.b == '1);

    int_div_regfile_multi_step #(
        .data_width    (data_width),
        .bits_per_cycle(bits_per_cycle)
    ) u_step (
        .rem_in   (rem),
        .dvd_bits (quot[data_width-1 -: bits_per_cycle]),
        .divisor  (divisor),
        .rem_out  (step_rem),
        .quot_bits(step_quot)
    );

    // The quotient register doubles as the dividend shifter: dividend bits leave
    // at the top while quotient bits enter at the bottom.
    assign quot_shift = data_width'({quot, step_quot});
    assign quot_fixed = neg_q ? -quot_shift : quot_shift;
    assign rem_fixed  = neg_r ? -step_rem : step_rem;

    // Control FSM, iteration counter, operand latch and write-port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            quot_sel <= '0;
            mod_sel  <= '0;
            quot     <= '0;
            rem      <= '0;
            divisor  <= '0;
            wr_req   <= 1'b0;
            wr_sel   <= '0;
            wr_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        neg_q    <= bus.is_signed & (bus.a[data_width-1] ^ bus.b[data_width-1]);
                        neg_r    <= bus.is_signed & bus.a[data_width-1];
                        quot_sel <= bus.r_quot_sel;
                        mod_sel  <= bus.r_mod_sel;
                        divisor  <= abs_b;
                        if (is_div0) begin
                            quot  <= '1;
                            rem   <= bus.a;
                            state <= first_write(bus.r_quot_sel, bus.r_mod_sel);
                        end else if (is_ovf) begin
                            quot  <= bus.a;
                            rem   <= '0;
                            state <= first_write(bus.r_quot_sel, bus.r_mod_sel);
                        end else begin
                            quot  <= abs_a;
                            rem   <= '0;
                            cnt   <= cnt_width'(steps - 1);
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (cnt == '0) begin
                        quot  <= quot_fixed;
                        rem   <= rem_fixed;
                        state <= first_write(quot_sel, mod_sel);
                    end else begin
                        quot <= quot_shift;
                        rem  <= step_rem;
                        cnt  <= cnt - cnt_width'(1);
                    end
                end
                ST_WRITE_QUOT: begin
                    if (!wr_req) begin
                        wr_req  <= 1'b1;
                        wr_sel  <= quot_sel;
                        wr_data <= quot;
                    end else if (bus.rf_wr_ack) begin
                        if (mod_sel != '0) begin
                            state   <= ST_WRITE_MOD;
                            wr_sel  <= mod_sel;
                            wr_data <= rem;
                        end else begin
                            state   <= ST_IDLE;
                            wr_req  <= 1'b0;
                            wr_sel  <= '0;
                            wr_data <= '0;
                        end
                    end
                end
                ST_WRITE_MOD: begin
                    if (!wr_req) begin
                        wr_req  <= 1'b1;
                        wr_sel  <= mod_sel;
                        wr_data <= rem;
                    end else if (bus.rf_wr_ack) begin
                        state   <= ST_IDLE;
                        wr_req  <= 1'b0;
                        wr_sel  <= '0;
                        wr_data <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy       = (state != ST_IDLE);
    assign bus.rf_wr_req  = wr_req;
    assign bus.rf_wr_sel  = wr_sel;
    assign bus.rf_wr_data = wr_data;

    // Flag unknown control or operand values at the points where they are used.
    always @(posedge clk) begin
        if (!rst) begin
            `INT_DIV_ASSERT_KNOWN(bus.req, "int_div_regfile_multi: X on req");
            if (state == ST_IDLE && bus.req)
                `INT_DIV_ASSERT_KNOWN({bus.is_signed, bus.r_quot_sel, bus.r_mod_sel, bus.a, bus.b},
                                      "int_div_regfile_multi: X on request operands");
            if (wr_req)
                `INT_DIV_ASSERT_KNOWN(bus.rf_wr_ack, "int_div_regfile_multi: X on rf_wr_ack");
        end
    end

endmodule

`undef INT_DIV_ASSERT_KNOWN

// File: tb/tb_int_div_regfile_multi.sv
// Scoreboard bench: two dividers (1 and 4 bits per cycle) share the stimulus;
// a monitor checks each register-file write and its start latency.
module tb_int_div_regfile_multi;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] data;
    } wr_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        req       = 1'b0;
    logic        is_signed = 1'b0;
    logic [4:0]  q_sel     = '0;
    logic [4:0]  m_sel     = '0;
    logic [31:0] a         = '0;
    logic [31:0] b         = '0;
    logic        ack [2]   = '{1'b0, 1'b0};

    logic        mon_req  [2];
    logic        mon_busy [2];
    logic [4:0]  mon_sel  [2];
    logic [31:0] mon_data [2];
    logic        prev_req [2] = '{1'b0, 1'b0};

    int   cyc       = 0;
    int   ack_delay = 0;
    int   wcnt [2]  = '{0, 0};
    int   n_tests   = 0;
    int   n_fail    = 0;
    wr_t  exp_q [2][$];
    int   lat_q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int_div_regfile_multi_if #(.data_width(32), .reg_sel_width(5)) bus0 ();
    int_div_regfile_multi_if #(.data_width(32), .reg_sel_width(5)) bus1 ();

    assign bus0.req        = req;
    assign bus0.is_signed  = is_signed;
    assign bus0.r_quot_sel = q_sel;
    assign bus0.r_mod_sel  = m_sel;
    assign bus0.a          = a;
    assign bus0.b          = b;
    assign bus0.rf_wr_ack  = ack[0];
    assign bus1.req        = req;
    assign bus1.is_signed  = is_signed;
    assign bus1.r_quot_sel = q_sel;
    assign bus1.r_mod_sel  = m_sel;
    assign bus1.a          = a;
    assign bus1.b          = b;
    assign bus1.rf_wr_ack  = ack[1];

    assign mon_req[0]  = bus0.rf_wr_req;
    assign mon_busy[0] = bus0.busy;
    assign mon_sel[0]  = bus0.rf_wr_sel;
    assign mon_data[0] = bus0.rf_wr_data;
    assign mon_req[1]  = bus1.rf_wr_req;
    assign mon_busy[1] = bus1.busy;
    assign mon_sel[1]  = bus1.rf_wr_sel;
    assign mon_data[1] = bus1.rf_wr_data;

    int_div_regfile_multi #(.data_width(32), .num_regs(32), .bits_per_cycle(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );
    int_div_regfile_multi #(.data_width(32), .num_regs(32), .bits_per_cycle(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register-file model: acks each write after ack_delay stalled cycles.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst || !mon_req[i]) begin
                ack[i]  = 1'b0;
                wcnt[i] = 0;
            end else if (ack[i]) begin
                wcnt[i] = 0;
                ack[i]  = (ack_delay == 0);
            end else if (wcnt[i] >= ack_delay) begin
                ack[i] = 1'b1;
            end else begin
                wcnt[i]++;
            end
        end
    end

    // Monitor: compares presented writes against the scoreboard front.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                prev_req[i] = 1'b0;
            end else begin
                if (mon_req[i] && !prev_req[i]) begin
                    if (lat_q[i].size() == 0) check($sformatf("unexpected_req%0d", i), 32'd1, 32'd0);
                    else check($sformatf("req_rise_cycle%0d", i), cyc, lat_q[i].pop_front());
                end
                if (mon_req[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("unexpected_write%0d", i), 32'd1, 32'd0);
                    end else begin
                        check($sformatf("wr_sel%0d", i), 32'(mon_sel[i]), 32'(exp_q[i][0].sel));
                        check($sformatf("wr_data%0d", i), mon_data[i], exp_q[i][0].data);
                        if (ack[i]) void'(exp_q[i].pop_front());
                    end
                end else begin
                    check($sformatf("idle_sel%0d", i), 32'(mon_sel[i]), 32'd0);
                    check($sformatf("idle_data%0d", i), mon_data[i], 32'd0);
                end
                prev_req[i] = mon_req[i];
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 400 && (mon_busy[0] || mon_busy[1]); k++) @(negedge clk);
        check("busy_fall0", 32'(mon_busy[0]), 32'd0);
        check("busy_fall1", 32'(mon_busy[1]), 32'd0);
    endtask

    task automatic do_div(input logic sgn, input logic [4:0] qs, input logic [4:0] ms,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eq, input logic [31:0] er,
                          input bit special, input int dly, input int pulse_at);
        wr_t w;
        int  acc;
        ack_delay = dly;
        @(negedge clk);
        is_signed = sgn; q_sel = qs; m_sel = ms; a = av; b = bv; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        acc = cyc;
        for (int i = 0; i < 2; i++) begin
            if (qs != 0) begin w.sel = qs; w.data = eq; exp_q[i].push_back(w); end
            if (ms != 0) begin w.sel = ms; w.data = er; exp_q[i].push_back(w); end
            if (qs != 0 || ms != 0)
                lat_q[i].push_back(acc + (special ? 1 : 1 + 32 / ((i == 0) ? 1 : 4)));
        end
        if (pulse_at > 0) begin
            repeat (pulse_at) @(negedge clk);
            a = 32'd1; b = 32'd1; q_sel = 5'd12; m_sel = 5'd13; req = 1'b1;
            @(negedge clk);
            req = 1'b0;
        end
        wait_idle();
        check("drain0", 32'(exp_q[0].size()), 32'd0);
        check("drain1", 32'(exp_q[1].size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d failures", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy0", 32'(mon_busy[0]), 32'd0);
        check("rst_req0", 32'(mon_req[0]), 32'd0);
        check("rst_sel0", 32'(mon_sel[0]), 32'd0);
        check("rst_data0", mon_data[0], 32'd0);
        check("rst_busy1", 32'(mon_busy[1]), 32'd0);
        check("rst_req1", 32'(mon_req[1]), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        //     sgn   qs     ms     a             b             quot          rem           spec dly pulse
        do_div(1'b0, 5'd5,  5'd6,  32'd100,      32'd7,        32'd14,       32'd2,        0,   0,  0);
        do_div(1'b1, 5'd3,  5'd4,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 0,   0,  0);
        do_div(1'b0, 5'd7,  5'd8,  32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1,   0,  0);
        do_div(1'b1, 5'd7,  5'd8,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1,   0,  0);
        do_div(1'b1, 5'd1,  5'd2,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1,   0,  0);
        do_div(1'b0, 5'd1,  5'd2,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 0,   0,  0);
        do_div(1'b0, 5'd15, 5'd16, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF,        0,   0,  0);
        do_div(1'b1, 5'd20, 5'd21, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        0,   5,  0);
        do_div(1'b0, 5'd0,  5'd9,  32'd1000,     32'd33,       32'd30,       32'd10,       0,   0,  0);
        do_div(1'b0, 5'd0,  5'd0,  32'd50,       32'd5,        32'd10,       32'd0,        0,   0,  0);
        do_div(1'b0, 5'd10, 5'd11, 32'd200,      32'd9,        32'd22,       32'd2,        0,   0,  4);

        // Abort mid-CALC: nothing from this request may reach the register file.
        @(negedge clk);
        is_signed = 1'b0; q_sel = 5'd1; m_sel = 5'd2; a = 32'd77; b = 32'd3; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy0", 32'(mon_busy[0]), 32'd0);
        check("abort_req0", 32'(mon_req[0]), 32'd0);
        check("abort_sel0", 32'(mon_sel[0]), 32'd0);
        check("abort_data0", mon_data[0], 32'd0);
        check("abort_busy1", 32'(mon_busy[1]), 32'd0);
        check("abort_req1", 32'(mon_req[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_div(1'b1, 5'd30, 5'd31, 32'hFFFFFFB3, 32'd3,        32'hFFFFFFE7, 32'hFFFFFFFE, 0,   0,  0);

        repeat (3) @(negedge clk);
        check("final_lat0", 32'(lat_q[0].size()), 32'd0);
        check("final_lat1", 32'(lat_q[1].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
